vexriscv_dbus_ram_bridge: RTL and testbench

- Responder for the VexRiscv simple data bus (dBus cmd/rsp); sits between the CPU data port and port B of the on-chip dual-port program/data RAM.
- Converts dBus commands into RAM-port strobes: enable, per-byte write enables, word address, write data.
- Times read responses against the RAM's configured read latency, 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE, output register).

---
 rtl/vexriscv_dbus_ram_bridge.sv | 165 ++++++++++++++++
 tb/tb_vexriscv_dbus_ram_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vexriscv_dbus_ram_bridge.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------------------------
// vexriscv_dbus_ram_bridge
//
// Responds to the VexRiscv simple data bus (dBus cmd/rsp) and drives port B of the on-chip
// dual-port RAM. Each accepted command becomes one cycle of RAM strobes. Read responses are
// timed to match the RAM read latency: 1 cycle (no output register) or 2 cycles (output
// register enabled through o_ram_regce).
//
// Optional feature (off by default):
//   DBUS_RAM_BRIDGE_ERROR_EN - flags misaligned and out-of-range accesses. Errored writes are
//   suppressed. Errored reads return rsp_error = 1 with zero data. A sticky flag records the
//   first error. When undefined, rsp_error is tied low and addresses wrap.
//
// Ports:
//   i_clk, i_rst_n        clock and asynchronous active-low reset
//   i_dbus_cmd_*          dBus command (valid, wr, byte address, lane-replicated data, size)
//   o_dbus_cmd_ready      command accepted when valid && ready
//   o_dbus_rsp_*          one-cycle read response strobe, error flag and data
//   o_ram_en/we/addr/din  RAM port strobes (word address, per-byte write enables)
//   o_ram_regce           RAM output register enable (RAM_LATENCY = 2 only)
//   i_ram_dout            RAM read data
// ---------------------------------------------------------------------------------------------
module vexriscv_dbus_ram_bridge #(
  parameter int unsigned RAM_WIDTH   = 32,
  parameter int unsigned RAM_DEPTH   = 16384,
  parameter int unsigned RAM_LATENCY = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  localparam int unsigned AW         = $clog2(RAM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_dbus_cmd_valid,
  output logic          o_dbus_cmd_ready,
  input  logic          i_dbus_cmd_wr,
  input  logic [31:0]   i_dbus_cmd_address,
  input  logic [31:0]   i_dbus_cmd_data,
  input  logic [1:0]    i_dbus_cmd_size,
  output logic          o_dbus_rsp_ready,
  output logic          o_dbus_rsp_error,
  output logic [31:0]   o_dbus_rsp_data,
  output logic          o_ram_en,
  output logic [3:0]    o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_din,
  output logic          o_ram_regce,
  input  logic [31:0]   i_ram_dout
);

  if (RAM_LATENCY != 1 && RAM_LATENCY != 2) begin : g_bad_latency
    $error("vexriscv_dbus_ram_bridge: RAM_LATENCY must be 1 or 2");
  end
  if (RAM_WIDTH != 32) begin : g_bad_width
    $error("vexriscv_dbus_ram_bridge: only RAM_WIDTH = 32 is supported");
  end

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_RD_WAIT = 1'b1;

  // Wait cycles left after the read-accept cycle, minus one.
  localparam logic LAT_M1 = 1'(RAM_LATENCY - 1);

  logic       r_state;
  logic       w_state_nxt;
  logic       r_cnt;
  logic       w_cnt_nxt;
  logic       w_final;
  logic       w_accept;
  logic       w_err;
  logic       w_rsp_err;
  logic [3:0] w_we_lanes;

  // Last wait cycle: the response goes out and a new command may be taken alongside it.
  assign w_final = (r_state == ST_RD_WAIT) && (r_cnt == 1'b0);

  assign o_dbus_cmd_ready = i_rst_n && ((r_state == ST_IDLE) || w_final);
  assign w_accept         = i_dbus_cmd_valid && o_dbus_cmd_ready;

  always_comb begin
    w_we_lanes = 4'b1111;
    case (i_dbus_cmd_size)
      2'd0:    w_we_lanes = 4'b0001 << i_dbus_cmd_address[1:0];
      2'd1:    w_we_lanes = i_dbus_cmd_address[1] ? 4'b1100 : 4'b0011;
      default: w_we_lanes = 4'b1111;
    endcase
  end

  assign o_ram_en   = w_accept && !w_err;
  assign o_ram_we   = (w_accept && i_dbus_cmd_wr && !w_err) ? w_we_lanes : 4'b0000;
  assign o_ram_addr = AW'((i_dbus_cmd_address - ADDR_BASE) >> 2);
  assign o_ram_din  = i_dbus_cmd_data;

  if (RAM_LATENCY == 2) begin : g_regce
    // First wait cycle: RAM array output is moved into its output register.
    assign o_ram_regce = (r_state == ST_RD_WAIT) && r_cnt;
  end else begin : g_no_regce
    assign o_ram_regce = 1'b0;
  end

  assign o_dbus_rsp_ready = w_final;
  assign o_dbus_rsp_error = w_final && w_rsp_err;
  assign o_dbus_rsp_data  = (w_final && !w_rsp_err) ? i_ram_dout : 32'h0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_accept && !i_dbus_cmd_wr) begin
      w_state_nxt = ST_RD_WAIT;
      w_cnt_nxt   = LAT_M1;
    end else if (r_state == ST_RD_WAIT) begin
      if (r_cnt != 1'b0) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef DBUS_RAM_BRIDGE_ERROR_EN
  localparam logic [32:0] ERR_LIMIT = 33'(RAM_DEPTH) << 2;

  logic [31:0] w_off;
  logic        w_misalign;
  logic        w_oob;
  logic        r_rd_err;
  logic        r_err_sticky;

  // Unsigned offset: addresses below the base wrap high and land out of range.
  assign w_off      = i_dbus_cmd_address - ADDR_BASE;
  assign w_oob      = {1'b0, w_off} >= ERR_LIMIT;
  assign w_misalign = ((i_dbus_cmd_size == 2'd1) && i_dbus_cmd_address[0]) ||
                      ((i_dbus_cmd_size == 2'd2) && (i_dbus_cmd_address[1:0] != 2'b00));
  assign w_err      = w_misalign || w_oob;
  assign w_rsp_err  = r_rd_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_err     <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_accept && !i_dbus_cmd_wr) begin
        r_rd_err <= w_err;
      end
      // Debug-only status flag, watched from simulation or an ILA.
      if (w_accept && w_err) begin
        r_err_sticky <= 1'b1;
      end
    end
  end
`else
  assign w_err     = 1'b0;
  assign w_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_vexriscv_dbus_ram_bridge.sv
`timescale 1ns/1ps
// Bench for vexriscv_dbus_ram_bridge: instance 0 uses RAM_LATENCY = 1, instance 1 uses
// RAM_LATENCY = 2, each backed by a behavioural RAM. Expected read responses (data, error,
// cycle) go into a per-instance queue at command accept and are popped on rsp_ready.
module tb_vexriscv_dbus_ram_bridge;

  localparam int unsigned DEPTH = 16384;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_wr    [2];
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_data  [2];
  logic [1:0]  cmd_size  [2];
  logic        cmd_ready [2];
  logic        rsp_ready [2];
  logic        rsp_error [2];
  logic [31:0] rsp_data  [2];
  logic        ram_en    [2];
  logic [3:0]  ram_we    [2];
  logic [13:0] ram_addr  [2];
  logic [31:0] ram_din   [2];
  logic        ram_regce [2];
  logic [31:0] ram_dout  [2];

  exp_t        sb [2][$];
  logic [31:0] shadow [int];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [DEPTH];
    logic [31:0] q1;
    logic [31:0] q2;

    vexriscv_dbus_ram_bridge #(
      .RAM_WIDTH  (32),
      .RAM_DEPTH  (DEPTH),
      .RAM_LATENCY(g + 1),
      .ADDR_BASE  (BASE)
    ) u_dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_dbus_cmd_valid  (cmd_valid[g]),
      .o_dbus_cmd_ready  (cmd_ready[g]),
      .i_dbus_cmd_wr     (cmd_wr[g]),
      .i_dbus_cmd_address(cmd_addr[g]),
      .i_dbus_cmd_data   (cmd_data[g]),
      .i_dbus_cmd_size   (cmd_size[g]),
      .o_dbus_rsp_ready  (rsp_ready[g]),
      .o_dbus_rsp_error  (rsp_error[g]),
      .o_dbus_rsp_data   (rsp_data[g]),
      .o_ram_en          (ram_en[g]),
      .o_ram_we          (ram_we[g]),
      .o_ram_addr        (ram_addr[g]),
      .o_ram_din         (ram_din[g]),
      .o_ram_regce       (ram_regce[g]),
      .i_ram_dout        (ram_dout[g])
    );

    // Read-first RAM: array output register q1, optional output register q2.
    always @(posedge clk) begin
      if (ram_en[g]) begin
        if (ram_we[g] == 4'b0000) q1 <= mem[ram_addr[g]];
        for (int b = 0; b < 4; b++) begin
          if (ram_we[g][b]) mem[ram_addr[g]][b*8 +: 8] <= ram_din[g][b*8 +: 8];
        end
      end
    end
    always @(posedge clk) if (ram_regce[g]) q2 <= q1;

    if (g == 0) begin : g_l1
      assign ram_dout[g] = q1;
    end else begin : g_l2
      assign ram_dout[g] = q2;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_we(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
`ifdef DBUS_RAM_BRIDGE_ERROR_EN
    logic [31:0] off;
    off = a - BASE;
    return ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00)) ||
           (off >= 32'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  // Present one command on instance g and hold it until accepted. Returns the number of
  // cycles spent waiting for cmd_ready and whether rsp_ready was high in the accept cycle.
  task automatic issue(input int g, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, output int waits, output logic rsp_seen);
    logic        err;
    logic [3:0]  we;
    logic [13:0] wa;
    logic [31:0] word;
    logic        done;
    int          key;
    err  = exp_err(sz, a);
    we   = exp_we(sz, a);
    wa   = 14'((a - BASE) >> 2);
    key  = g * DEPTH + int'(wa);
    cmd_valid[g] = 1'b1;
    cmd_wr[g]    = wr;
    cmd_addr[g]  = a;
    cmd_data[g]  = d;
    cmd_size[g]  = sz;
    waits    = 0;
    done     = 1'b0;
    rsp_seen = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready[g]) begin
        done     = 1'b1;
        rsp_seen = rsp_ready[g];
        check_eq("ram_en", 64'(ram_en[g]), 64'(!err));
        check_eq("ram_we", 64'(ram_we[g]), (wr && !err) ? 64'(we) : 64'h0);
        if (!err) check_eq("ram_addr", 64'(ram_addr[g]), 64'(wa));
        word = shadow.exists(key) ? shadow[key] : 32'h0;
        if (wr && !err) begin
          check_eq("ram_din", 64'(ram_din[g]), 64'(d));
          for (int b = 0; b < 4; b++) if (we[b]) word[b*8 +: 8] = d[b*8 +: 8];
          shadow[key] = word;
        end
        if (!wr) sb[g].push_back('{data: err ? 32'h0 : word, err: err, cyc: cyc + g + 1});
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid[g] = 1'b0;
    if (!done) check_eq("accept_timeout", 64'(done), 64'h1);
  endtask

  task automatic check_quiet_outputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq({tag, "_cmd_ready"}, 64'(cmd_ready[g]), 64'h0);
      check_eq({tag, "_rsp_ready"}, 64'(rsp_ready[g]), 64'h0);
      check_eq({tag, "_rsp_error"}, 64'(rsp_error[g]), 64'h0);
      check_eq({tag, "_rsp_data"}, 64'(rsp_data[g]), 64'h0);
      check_eq({tag, "_ram_en"}, 64'(ram_en[g]), 64'h0);
      check_eq({tag, "_ram_we"}, 64'(ram_we[g]), 64'h0);
      check_eq({tag, "_ram_regce"}, 64'(ram_regce[g]), 64'h0);
    end
  endtask

  // Response monitor: every rsp_ready pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 2; g++) begin
        if (rsp_ready[g]) begin
          if (sb[g].size() == 0) begin
            check_eq("rsp_unexpected", 64'(rsp_ready[g]), 64'h0);
          end else begin
            exp_t e;
            e = sb[g].pop_front();
            check_eq("rsp_data", 64'(rsp_data[g]), 64'(e.data));
            check_eq("rsp_error", 64'(rsp_error[g]), 64'(e.err));
            check_eq("rsp_cycle", 64'(cyc), 64'(e.cyc));
          end
        end else begin
          check_eq("rsp_data_idle", 64'(rsp_data[g]), 64'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w;
    logic rs;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      cmd_valid[g] = 1'b1;
      cmd_wr[g]    = 1'b1;
      cmd_addr[g]  = BASE;
      cmd_data[g]  = 32'hFFFF_FFFF;
      cmd_size[g]  = 2'd2;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet_outputs("reset");
    for (int g = 0; g < 2; g++) cmd_valid[g] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_cmd_ready0", 64'(cmd_ready[0]), 64'h1);
    check_eq("idle_cmd_ready1", 64'(cmd_ready[1]), 64'h1);
    @(posedge clk);
    #1;

    // Word write then read, latency 2; a following read waits one cycle.
    issue(1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, w, rs);
    issue(1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, w, rs);
    issue(1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, w, rs);
    check_eq("l2_read_wait", 64'(w), 64'h1);

    // Byte and halfword lanes.
    issue(1, 1'b1, 32'h8000_0020, 32'h1122_3344, 2'd2, w, rs);
    issue(1, 1'b1, 32'h8000_0020, 32'h6666_6666, 2'd1, w, rs);
    issue(1, 1'b1, 32'h8000_0023, 32'h5555_5555, 2'd0, w, rs);
    issue(1, 1'b1, 32'h8000_0002, 32'hABCD_ABCD, 2'd1, w, rs);
    issue(1, 1'b0, 32'h8000_0020, 32'h0, 2'd2, w, rs);
    issue(1, 1'b0, 32'h8000_0000, 32'h0, 2'd2, w, rs);

    // Back-to-back reads, latency 1.
    for (int i = 0; i < 4; i++) issue(0, 1'b1, BASE + 32'(4 * i), 32'(i + 1), 2'd2, w, rs);
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, BASE + 32'(4 * i), 32'h0, 2'd2, w, rs);
      check_eq("l1_b2b_wait", 64'(w), 64'h0);
      if (i > 0) check_eq("l1_b2b_rsp", 64'(rs), 64'h1);
    end

    // Write accepted in the response cycle of a latency-2 read.
    issue(1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, w, rs);
    issue(1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, w, rs);
    check_eq("overlap_wait", 64'(w), 64'h1);
    check_eq("overlap_rsp", 64'(rs), 64'h1);
    issue(1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, w, rs);
    repeat (3) @(posedge clk);
    #1;

    // Reset one cycle after a read is accepted: the response must never appear.
    issue(1, 1'b0, 32'h8000_0020, 32'h0, 2'd2, w, rs);
    rst_n = 1'b0;
    sb[1].delete();
    @(negedge clk);
    check_quiet_outputs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h8000_0020, 32'h0, 2'd2, w, rs);

`ifdef DBUS_RAM_BRIDGE_ERROR_EN
    issue(1, 1'b0, 32'h8000_0002, 32'h0, 2'd2, w, rs);
    issue(1, 1'b1, 32'h8001_0000, 32'h1234_5678, 2'd2, w, rs);
    issue(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 2'd2, w, rs);
    issue(0, 1'b0, 32'h8000_0001, 32'h0, 2'd1, w, rs);
    issue(1, 1'b0, 32'h8000_0010, 32'h0, 2'd2, w, rs);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("sb0_drained", 64'(sb[0].size()), 64'h0);
    check_eq("sb1_drained", 64'(sb[1].size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
